iter_alu: RTL and testbench

Registered 32-bit ALU that executes the 4-bit operation code produced by the ALU control stage. It sits directly downstream of ALU control in the execute stage of the Lab CPU datapath. Single-cycle operations complete in one clock. MUL runs as a 32-iteration shift-add sequence behind a valid/busy handshake, so the datapath can stall on it.

---
 rtl/iter_alu.sv | 156 +++++++++++++++
 tb/tb_iter_alu.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_alu.sv
// iter_alu: registered 32-bit execute-stage ALU.
// Single-cycle ops complete on the accepting edge. MUL is an iterative
// shift-add multiply behind a valid/busy handshake so the pipeline can stall.
module iter_alu #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [3:0]        ctrl_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic [4:0]        shamt_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              overflow_o,
    output logic              valid_o,
    output logic              busy_o
);

    // Counter must be able to hold DATA_W itself, hence the extra bit.
    localparam int CNT_W = $clog2(DATA_W) + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_SRA = 4'd5;
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_SLL = 4'd14;

    logic [0:0]        r_state;
    logic [DATA_W-1:0] r_result;
    logic              r_zero;
    logic              r_overflow;
    logic              r_valid;
    logic              r_busy;
    logic [DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [DATA_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_count;

    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_ovf;
    logic [DATA_W-1:0] w_acc_step;
    logic [CNT_W-1:0]  w_count_next;
    logic              w_mul_done;

    // Single-cycle result and signed overflow for the presented request.
    always_comb begin
        w_sum     = src1_i + src2_i;
        w_diff    = src1_i - src2_i;
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        case (ctrl_i)
            OP_AND: w_alu_res = src1_i & src2_i;
            OP_OR:  w_alu_res = src1_i | src2_i;
            OP_ADD: begin
                w_alu_res = w_sum;
                // Same operand signs, result sign flipped.
                w_alu_ovf = (src1_i[DATA_W-1] == src2_i[DATA_W-1]) &&
                            (w_sum[DATA_W-1] != src1_i[DATA_W-1]);
            end
            OP_SUB: begin
                w_alu_res = w_diff;
                // Effective addend is -src2, so the signs must differ.
                w_alu_ovf = (src1_i[DATA_W-1] != src2_i[DATA_W-1]) &&
                            (w_diff[DATA_W-1] != src1_i[DATA_W-1]);
            end
            OP_SRA: w_alu_res = $unsigned($signed(src2_i) >>> shamt_i);
            OP_SLT: w_alu_res = {{(DATA_W-1){1'b0}},
                                 ($signed(src1_i) < $signed(src2_i))};
            OP_SLL: w_alu_res = src2_i << shamt_i;
            default: begin
                w_alu_res = '0;
                w_alu_ovf = 1'b0;
            end
        endcase
    end

    // One shift-add iteration; the final iteration's sum is the product.
    always_comb begin
        w_acc_step   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
        w_count_next = r_count + 1'b1;
        w_mul_done   = (r_state == S_MUL) && (w_count_next == CNT_W'(DATA_W));
    end

    // Control FSM, multiply datapath and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_result   <= '0;
            r_zero     <= 1'b1;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_count    <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (valid_i) begin
                        if (ctrl_i == OP_MUL) begin
                            r_mcand  <= src1_i;
                            r_mplier <= src2_i;
                            r_acc    <= '0;
                            r_count  <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= S_MUL;
                        end else begin
                            r_result   <= w_alu_res;
                            r_zero     <= (w_alu_res == '0);
                            r_overflow <= w_alu_ovf;
                            r_valid    <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_step;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= w_count_next;
                    if (w_mul_done) begin
                        r_result   <= w_acc_step;
                        r_zero     <= (w_acc_step == '0);
                        r_overflow <= 1'b0;
                        r_valid    <= 1'b1;
                        r_busy     <= 1'b0;
                        r_count    <= '0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign result_o   = r_result;
    assign zero_o     = r_zero;
    assign overflow_o = r_overflow;
    assign valid_o    = r_valid;
    assign busy_o     = r_busy;

endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: directed self-checking bench for iter_alu.
module tb_iter_alu;

    localparam logic [3:0] C_AND = 4'd0;
    localparam logic [3:0] C_OR  = 4'd1;
    localparam logic [3:0] C_ADD = 4'd2;
    localparam logic [3:0] C_SUB = 4'd3;
    localparam logic [3:0] C_SRA = 4'd5;
    localparam logic [3:0] C_UNL = 4'd6;
    localparam logic [3:0] C_SLT = 4'd7;
    localparam logic [3:0] C_MUL = 4'd8;
    localparam logic [3:0] C_SLL = 4'd14;

    logic        clk_i;
    logic        rst_i;
    logic        valid_i;
    logic [3:0]  ctrl_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic [4:0]  shamt_i;
    logic [31:0] result_o;
    logic        zero_o;
    logic        overflow_o;
    logic        valid_o;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    iter_alu #(.DATA_W(32)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .ctrl_i     (ctrl_i),
        .src1_i     (src1_i),
        .src2_i     (src2_i),
        .shamt_i    (shamt_i),
        .result_o   (result_o),
        .zero_o     (zero_o),
        .overflow_o (overflow_o),
        .valid_o    (valid_o),
        .busy_o     (busy_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Present one request for one edge; returns 1 time unit after that edge.
    task automatic issue(input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
        ctrl_i  = c;
        src1_i  = a;
        src2_i  = b;
        shamt_i = sh;
        valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        $display("op ctrl=%0d a=%h b=%h sh=%0d -> result=%h zero=%b ovf=%b valid=%b",
                 c, a, b, sh, result_o, zero_o, overflow_o, valid_o);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        n_checks++; if (result_o !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=%h", result_o, 32'h0); end
        n_checks++; if (zero_o !== 1'b1) begin n_fail++; $display("FAIL reset_zero got=%b exp=1", zero_o); end
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", overflow_o); end
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL idle_valid got=%b exp=0", valid_o); end
        $display("reset: result=%h zero=%b busy=%b", result_o, zero_o, busy_o);
    endtask

    task automatic test_add_sub();
        issue(C_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0);
        n_checks++; if (result_o !== 32'h8000_0000) begin n_fail++; $display("FAIL add_ovf_result got=%h exp=%h", result_o, 32'h8000_0000); end
        n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL add_ovf_flag got=%b exp=1", overflow_o); end
        n_checks++; if (zero_o !== 1'b0) begin n_fail++; $display("FAIL add_ovf_zero got=%b exp=0", zero_o); end
        n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL add_ovf_valid got=%b exp=1", valid_o); end
        @(posedge clk_i); #1;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL add_valid_pulse got=%b exp=0", valid_o); end
        n_checks++; if (result_o !== 32'h8000_0000) begin n_fail++; $display("FAIL add_result_hold got=%h exp=%h", result_o, 32'h8000_0000); end

        issue(C_SUB, 32'd5, 32'd5, 5'd0);
        n_checks++; if (result_o !== 32'h0) begin n_fail++; $display("FAIL sub_zero_result got=%h exp=0", result_o); end
        n_checks++; if (zero_o !== 1'b1) begin n_fail++; $display("FAIL sub_zero_flag got=%b exp=1", zero_o); end
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL sub_zero_ovf got=%b exp=0", overflow_o); end

        issue(C_SUB, 32'h8000_0000, 32'h1, 5'd0);
        n_checks++; if (result_o !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL sub_ovf_result got=%h exp=%h", result_o, 32'h7FFF_FFFF); end
        n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL sub_ovf_flag got=%b exp=1", overflow_o); end

        issue(C_SUB, 32'h0, 32'h1, 5'd0);
        n_checks++; if (result_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sub_neg_result got=%h exp=%h", result_o, 32'hFFFF_FFFF); end
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL sub_neg_ovf got=%b exp=0", overflow_o); end
    endtask

    task automatic test_logic_shift_cmp();
        issue(C_AND, 32'h0000_F0F0, 32'h0000_FF00, 5'd0);
        n_checks++; if (result_o !== 32'h0000_F000) begin n_fail++; $display("FAIL and got=%h exp=%h", result_o, 32'h0000_F000); end
        issue(C_OR, 32'h0000_F0F0, 32'h0000_FF00, 5'd0);
        n_checks++; if (result_o !== 32'h0000_FFF0) begin n_fail++; $display("FAIL or got=%h exp=%h", result_o, 32'h0000_FFF0); end
        issue(C_SRA, 32'h0, 32'h8000_0000, 5'd4);
        n_checks++; if (result_o !== 32'hF800_0000) begin n_fail++; $display("FAIL sra got=%h exp=%h", result_o, 32'hF800_0000); end
        issue(C_SRA, 32'h0, 32'h4000_0000, 5'd4);
        n_checks++; if (result_o !== 32'h0400_0000) begin n_fail++; $display("FAIL sra_pos got=%h exp=%h", result_o, 32'h0400_0000); end
        issue(C_SLL, 32'h0, 32'h1, 5'd31);
        n_checks++; if (result_o !== 32'h8000_0000) begin n_fail++; $display("FAIL sll got=%h exp=%h", result_o, 32'h8000_0000); end
        issue(C_SLT, 32'hFFFF_FFFF, 32'h1, 5'd0);
        n_checks++; if (result_o !== 32'h1) begin n_fail++; $display("FAIL slt_true got=%h exp=1", result_o); end
        issue(C_SLT, 32'h1, 32'hFFFF_FFFF, 5'd0);
        n_checks++; if (result_o !== 32'h0) begin n_fail++; $display("FAIL slt_false got=%h exp=0", result_o); end
        n_checks++; if (zero_o !== 1'b1) begin n_fail++; $display("FAIL slt_false_zero got=%b exp=1", zero_o); end
        issue(C_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0);
        issue(C_UNL, 32'h1234_5678, 32'h7FFF_FFFF, 5'd3);
        n_checks++; if (result_o !== 32'h0) begin n_fail++; $display("FAIL unlisted got=%h exp=0", result_o); end
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL unlisted_ovf got=%b exp=0", overflow_o); end
        n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL unlisted_valid got=%b exp=1", valid_o); end
    endtask

    task automatic test_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_p);
        int n;
        int pulses;
        n = 0;
        issue(C_MUL, a, b, 5'd0);
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL mul_busy_start got=%b exp=1", busy_o); end
        // Accept edge is T; we now sit in cycle T+1. Completion edge is T+32.
        while (valid_o !== 1'b1 && n < 40) begin
            @(posedge clk_i); #1;
            n++;
        end
        n_checks++; if (n !== 32) begin n_fail++; $display("FAIL mul_latency got=%0d exp=32", n); end
        n_checks++; if (result_o !== exp_p) begin n_fail++; $display("FAIL mul_result got=%h exp=%h", result_o, exp_p); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL mul_busy_done got=%b exp=0", busy_o); end
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL mul_ovf got=%b exp=0", overflow_o); end
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            if (valid_o === 1'b1) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL mul_extra_pulses got=%0d exp=0", pulses); end
        $display("mul %h * %h -> %h after %0d cycles", a, b, result_o, n);
    endtask

    task automatic test_mul_busy();
        int n;
        int early;
        issue(C_ADD, 32'd10, 32'd20, 5'd0);
        n_checks++; if (result_o !== 32'd30) begin n_fail++; $display("FAIL busy_pre_add got=%h exp=%h", result_o, 32'd30); end
        issue(C_MUL, 32'd3, 32'd4, 5'd0);
        // Hold an ADD request for the whole multiply.
        ctrl_i  = C_ADD;
        src1_i  = 32'd1;
        src2_i  = 32'd2;
        valid_i = 1'b1;
        n = 0;
        early = 0;
        while (valid_o !== 1'b1 && n < 40) begin
            if (result_o !== 32'd30) early++;
            @(posedge clk_i); #1;
            n++;
        end
        n_checks++; if (early !== 0) begin n_fail++; $display("FAIL busy_ignored got=%0d changes exp=0", early); end
        n_checks++; if (n !== 32) begin n_fail++; $display("FAIL busy_mul_latency got=%0d exp=32", n); end
        n_checks++; if (result_o !== 32'd12) begin n_fail++; $display("FAIL busy_mul_result got=%h exp=%h", result_o, 32'd12); end
        // Completion cycle: busy is low, the held ADD is taken on this edge.
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        n_checks++; if (result_o !== 32'd3) begin n_fail++; $display("FAIL busy_add_after got=%h exp=%h", result_o, 32'd3); end
        n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL busy_add_valid got=%b exp=1", valid_o); end
        @(posedge clk_i); #1;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL busy_add_once got=%b exp=0", valid_o); end
        $display("mul busy: held ADD -> result=%h", result_o);
    endtask

    task automatic test_reset_mid_mul();
        int pulses;
        issue(C_MUL, 32'd5, 32'd7, 5'd0);
        repeat (9) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        n_checks++; if (result_o !== 32'h0) begin n_fail++; $display("FAIL midrst_result got=%h exp=0", result_o); end
        n_checks++; if (zero_o !== 1'b1) begin n_fail++; $display("FAIL midrst_zero got=%b exp=1", zero_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy_o); end
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got=%b exp=0", valid_o); end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i); #1;
            if (valid_o === 1'b1) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL midrst_no_valid got=%0d exp=0", pulses); end
        issue(C_ADD, 32'd2, 32'd2, 5'd0);
        n_checks++; if (result_o !== 32'd4) begin n_fail++; $display("FAIL midrst_add got=%h exp=%h", result_o, 32'd4); end
        n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL midrst_add_valid got=%b exp=1", valid_o); end
    endtask

    task automatic test_back_to_back();
        ctrl_i = C_ADD; src1_i = 32'd1; src2_i = 32'd1; shamt_i = 5'd0; valid_i = 1'b1;
        @(posedge clk_i); #1;
        n_checks++; if (valid_o !== 1'b1 || result_o !== 32'd2) begin n_fail++; $display("FAIL b2b_0 got=%b/%h exp=1/%h", valid_o, result_o, 32'd2); end
        ctrl_i = C_OR; src1_i = 32'h0000_00F0; src2_i = 32'h0000_000F;
        @(posedge clk_i); #1;
        n_checks++; if (valid_o !== 1'b1 || result_o !== 32'h0000_00FF) begin n_fail++; $display("FAIL b2b_1 got=%b/%h exp=1/%h", valid_o, result_o, 32'hFF); end
        ctrl_i = C_SLL; src2_i = 32'h3; shamt_i = 5'd4;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        n_checks++; if (valid_o !== 1'b1 || result_o !== 32'h30) begin n_fail++; $display("FAIL b2b_2 got=%b/%h exp=1/%h", valid_o, result_o, 32'h30); end
        @(posedge clk_i); #1;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got=%b exp=0", valid_o); end
        $display("back-to-back: last result=%h", result_o);
    endtask

    initial begin
        rst_i   = 1'b1;
        valid_i = 1'b0;
        ctrl_i  = 4'd0;
        src1_i  = '0;
        src2_i  = '0;
        shamt_i = '0;
        test_reset();
        test_add_sub();
        test_logic_shift_cmp();
        test_mul(32'h0001_0001, 32'h0001_0001, 32'h0002_0001);
        test_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        test_mul_busy();
        test_reset_mid_mul();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
